seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Frame controller for the 2-bit-symbol sequence detector. Accepts 8-bit words over a valid/ready handshake and serializes them MSB-first into 2-bit symbols on the detector's `data` input. It counts the detector's `success` pulses per frame, flushes the detector back to its idle state after each frame, and reports a per-frame hit count. It sits between the upstream byte source and the detector instance; the detector shares `clk`/`rst_n` with it.

## Interface
- `CNT_W`, 8, width of the per-frame hit counter (saturating)
- `FLUSH_SYMS`, 2, number of 2'b00 flush symbols driven after the last word (minimum 2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  controller can accept a word this cycle
- `in_data`  in  8  word; symbols are sent as [7:6], [5:4], [3:2], [1:0]
- `in_last`  in  1  word is the last of its frame (sampled with the handshake)
- `abort`  in  1  synchronous frame abort
- `det_data`  out  2  symbol to detector `data`
- `det_success`  in  1  detector `success` (registered in the detector)
- `hit_count`  out  CNT_W  hits in the current or most recent frame
- `frame_done`  out  1  one-cycle pulse at end of frame
- `frame_aborted`  out  1  qualifies `frame_done`: frame ended by `abort`

## Operation
- States: IDLE, SHIFT, FLUSH, DONE. Reset → IDLE.
- Reset values: `in_ready`=1 (combinational from IDLE), `det_data`=2'b00, `hit_count`=0, `frame_done`=0, `frame_aborted`=0. The shift register, symbol counter and flush counter are all 0.
- Handshake: a transfer occurs when `in_valid && in_ready`. `in_ready` = IDLE, or (SHIFT && sym_cnt==3 && !last_q && !abort).
- IDLE:
  - `det_data`=00.
  - On a transfer: load the shift register, latch `in_last` into last_q, set sym_cnt=0, clear `hit_count` and `frame_aborted`, go to SHIFT.
  - `abort` is ignored in IDLE.
- SHIFT:
  - `det_data`=shreg[7:6]; shift left by 2 each cycle; sym_cnt increments.
  - At sym_cnt==3 with !last_q: if a transfer occurs, reload and stay in SHIFT (back-to-back, no bubble).
  - At sym_cnt==3 with !last_q and no word available: drive 2'b00 fill symbols and keep `in_ready`=1 until a word arrives. Fill symbols are part of the stream.
  - At sym_cnt==3 with last_q: go to FLUSH.
- FLUSH: `det_data`=00 for FLUSH_SYMS cycles, then go to DONE. Two 00 symbols return the detector to S0 from any state.
- DONE: `frame_done`=1 for one cycle, then go to IDLE. `hit_count` and `frame_aborted` hold until the next frame start.
- Counting:
  - `hit_count` increments when `det_success`=1 while in SHIFT or FLUSH.
  - It saturates at 2^CNT_W−1 and never wraps.
  - 00 symbols cannot create success, so flush and fill symbols are never counted.
- Abort:
  - `abort` in SHIFT or FLUSH sets `frame_aborted`, discards the remaining symbols, goes to FLUSH and restarts the flush count. `in_ready`=0.
  - `det_success` for the symbol already presented is still counted.
  - Abort takes priority over a simultaneous reload.
- Async reset mid-frame: immediate return to reset values. The frame is lost and no `frame_done` is issued.

## Timing
- Word accepted at cycle t (IDLE): its symbols appear on `det_data` at t+1..t+4.
- Next word accepted at t+4: its symbols appear at t+5..t+8.
- Detector success for the symbol at cycle k arrives at k+1 and is reflected in `hit_count` at k+2.
- Single-word frame accepted at t: FLUSH at t+5..t+6, `frame_done` at t+7 with final `hit_count`. The next word can be accepted at t+8.
- End-to-end: `frame_done` = last-symbol cycle + FLUSH_SYMS + 1.

## Structure
- Package `seq_detect_pkg`:
  - state enum
  - `SYM_PER_WORD`=4
  - `FLUSH_SYM`=2'b00
  - symbol width 2, word width 8
- Natural sub-module: `seq_sym_serializer`. It holds the shift register and sym_cnt and produces `det_data` and a last-symbol flag. The FSM and counter stay in the top.
- The bench-level wrapper instantiates `seq_detect_ctrl` plus the detector.

## Test plan
- Reset, then single-word frame 8'hB2 (10,11,00,10) with `in_last`=1 → `det_data` sequence 10,11,00,10,00,00; `frame_done` at t+7; `hit_count`=1; `frame_aborted`=0.
- Frame 8'h59 then 8'h00 (`in_last` on the second) back-to-back → `in_ready` high at t+4; no bubble on `det_data`; `hit_count`=1.
- Frame 8'h00 ×3 → `hit_count`=0; `frame_done` pulses once.
- CNT_W=2, frame of five 8'h59 words → `hit_count` saturates at 3.
- `abort` in the 2nd symbol of 8'hB2 → only 10,11 are sent, then 00,00; `frame_done` with `frame_aborted`=1; `hit_count`=0. The next frame 8'hB2 → `hit_count`=1, proving the detector was flushed.
- `rst_n` low mid-SHIFT → all outputs at reset values asynchronously; no `frame_done`; a new frame completes normally.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 2-bit-symbol sequence detector frame controller.
package seq_detect_pkg;

    localparam int SYM_W        = 2;
    localparam int WORD_W       = 8;
    localparam int SYM_PER_WORD = 4;

    localparam logic [SYM_W-1:0] FLUSH_SYM    = 2'b00;
    localparam logic [1:0]       LAST_SYM_IDX = 2'(SYM_PER_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_sym_serializer.sv
// MSB-first word-to-symbol shifter; the register empties to zero so its top
// symbol doubles as the fill/flush value once a word has been fully sent.
module seq_sym_serializer
    import seq_detect_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_word,
    output logic [SYM_W-1:0]  o_sym,
    output logic              o_last_sym
);

    logic [WORD_W-1:0] r_shreg;
    logic [1:0]        r_sym_cnt;

    // Shift register and symbol index; load wins over shift, clear wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= 8'h00;
            r_sym_cnt <= 2'd0;
        end else if (i_clear) begin
            r_shreg   <= 8'h00;
            r_sym_cnt <= 2'd0;
        end else if (i_load) begin
            r_shreg   <= i_word;
            r_sym_cnt <= 2'd0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[WORD_W-SYM_W-1:0], FLUSH_SYM};
            if (r_sym_cnt != LAST_SYM_IDX) begin
                r_sym_cnt <= r_sym_cnt + 2'd1;
            end else begin
                r_sym_cnt <= r_sym_cnt;
            end
        end else begin
            r_shreg   <= r_shreg;
            r_sym_cnt <= r_sym_cnt;
        end
    end

    assign o_sym      = r_shreg[WORD_W-1 -: SYM_W];
    assign o_last_sym = (r_sym_cnt == LAST_SYM_IDX);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: feeds words to the detector as symbols, counts detector
// hits per frame, and flushes the detector back to idle at each frame end.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FLUSH_SYMS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              abort,
    output logic [SYM_W-1:0]  det_data,
    input  logic              det_success,
    output logic [CNT_W-1:0]  hit_count,
    output logic              frame_done,
    output logic              frame_aborted
);

    localparam int              FC_W       = $clog2(FLUSH_SYMS + 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_SYMS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e          r_state;
    state_e          w_next;
    logic            r_last_q;
    logic [FC_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_hit_count;
    logic            r_frame_done;
    logic            r_frame_aborted;
    logic            w_load;
    logic            w_shift;
    logic            w_clear;
    logic            w_in_ready;
    logic            w_sym_last;
    logic            w_active;
    logic            w_start;

    seq_sym_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_clear    (w_clear),
        .i_word     (in_data),
        .o_sym      (det_data),
        .o_last_sym (w_sym_last)
    );

    assign w_active = (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    assign w_start  = (r_state == ST_IDLE) && w_load;

    // Next-state, handshake and serializer control decode.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort || (w_sym_last && r_last_q)) begin
                    w_clear = 1'b1;
                    w_next  = ST_FLUSH;
                end else if (w_sym_last) begin
                    // Empty shifter keeps emitting 00 fill until the next word lands.
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end else begin
                    w_shift = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (!abort && (r_flush_cnt == FLUSH_LAST)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FLUSH;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register and latched last-word flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_last_q <= in_last;
            end else begin
                r_last_q <= r_last_q;
            end
        end
    end

    // Flush length counter; an abort restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= {FC_W{1'b0}};
        end else if ((w_next == ST_FLUSH) && ((r_state != ST_FLUSH) || abort)) begin
            r_flush_cnt <= {FC_W{1'b0}};
        end else if (r_state == ST_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + FC_W'(1);
        end else begin
            r_flush_cnt <= {FC_W{1'b0}};
        end
    end

    // Per-frame saturating hit counter, abort flag and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count     <= {CNT_W{1'b0}};
            r_frame_aborted <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= (w_next == ST_DONE);
            if (w_start) begin
                r_hit_count     <= {CNT_W{1'b0}};
                r_frame_aborted <= 1'b0;
            end else begin
                if (w_active && det_success && (r_hit_count != CNT_MAX)) begin
                    r_hit_count <= r_hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_hit_count <= r_hit_count;
                end
                if (w_active && abort) begin
                    r_frame_aborted <= 1'b1;
                end else begin
                    r_frame_aborted <= r_frame_aborted;
                end
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign hit_count     = r_hit_count;
    assign frame_done    = r_frame_done;
    assign frame_aborted = r_frame_aborted;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl with a small in-bench detector (hits on 11,00,10 and
// 01,10,01); expected streams and hit counts come from a per-frame symbol list.
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, abort, det_success;
    logic [7:0] in_data;
    logic       in_ready, in_ready_s;
    logic [1:0] det_data, det_data_s;
    logic [7:0] hit_count;
    logic [1:0] hit_count_s;
    logic       frame_done, frame_done_s, frame_aborted, frame_aborted_s;

    int total = 0;
    int bad   = 0;

    logic [7:0] words[8];
    int         gaps[8];
    int         n_words;
    int         abort_at;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.CNT_W(8), .FLUSH_SYMS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .abort(abort), .det_data(det_data),
        .det_success(det_success), .hit_count(hit_count), .frame_done(frame_done),
        .frame_aborted(frame_aborted));

    seq_detect_ctrl #(.CNT_W(2), .FLUSH_SYMS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .abort(abort), .det_data(det_data_s),
        .det_success(det_success), .hit_count(hit_count_s), .frame_done(frame_done_s),
        .frame_aborted(frame_aborted_s));

    function automatic bit is_hit(logic [1:0] a, logic [1:0] b, logic [1:0] c);
        return ((a == 2'b11) && (b == 2'b00) && (c == 2'b10)) ||
               ((a == 2'b01) && (b == 2'b10) && (c == 2'b01));
    endfunction

    logic [3:0] det_hist;
    // Stand-in detector: registered success one cycle after the completing symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_hist    <= 4'h0;
            det_success <= 1'b0;
        end else begin
            det_hist    <= {det_hist[1:0], det_data};
            det_success <= is_hit(det_hist[3:2], det_hist[1:0], det_data);
        end
    end

    task automatic run_frame(input string name);
        logic [1:0] exp_q[$];
        logic [1:0] pa, pb;
        int full_len, len, hits, exp8, exp2, k, gap_rem, done_rel, done_cnt, stream_bad;
        exp_q = {};
        for (int i = 0; i < n_words; i++) begin
            if (i > 0) for (int g = 0; g < gaps[i]; g++) exp_q.push_back(2'b00);
            for (int s = 0; s < 4; s++) exp_q.push_back(words[i][7-2*s -: 2]);
        end
        full_len = exp_q.size();
        if (abort_at >= 0 && abort_at < full_len) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
        end else if (abort_at >= full_len) begin
            for (int i = 0; i <= abort_at - full_len; i++) exp_q.push_back(2'b00);
        end
        for (int i = 0; i < 2; i++) exp_q.push_back(2'b00);
        len  = exp_q.size();
        hits = 0;
        pa = 2'b00; pb = 2'b00;
        foreach (exp_q[i]) begin
            if (is_hit(pa, pb, exp_q[i])) hits++;
            pa = pb; pb = exp_q[i];
        end
        exp8 = (hits > 255) ? 255 : hits;
        exp2 = (hits > 3) ? 3 : hits;

        @(negedge clk);
        abort = 1'b0; in_valid = 1'b1; in_data = words[0]; in_last = (n_words == 1);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_idle: got=%b want=1", name, in_ready);
        end
        @(posedge clk);
        k = 1; gap_rem = (n_words > 1) ? gaps[1] : 0;
        done_rel = -1; done_cnt = 0; stream_bad = 0;
        for (int rel = 0; rel <= len + 1; rel++) begin
            @(negedge clk);
            if (rel < len && (det_data !== exp_q[rel] || det_data_s !== exp_q[rel])) stream_bad++;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
            end
            if (rel == len) begin
                total += 4;
                if (hit_count !== 8'(exp8)) begin
                    bad++; $display("FAIL %s hit_count: got=%0d want=%0d", name, hit_count, exp8);
                end
                if (hit_count_s !== 2'(exp2)) begin
                    bad++; $display("FAIL %s hit_count_sat: got=%0d want=%0d", name, hit_count_s, exp2);
                end
                if (frame_aborted !== (abort_at >= 0)) begin
                    bad++; $display("FAIL %s frame_aborted: got=%b want=%b", name, frame_aborted, abort_at >= 0);
                end
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL %s ready_in_done: got=%b want=0", name, in_ready);
                end
            end
            if (rel == len + 1) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL %s ready_after_done: got=%b want=1", name, in_ready);
                end
            end
            abort = (rel == abort_at);
            if (k < n_words && gap_rem == 0 && !(abort_at >= 0 && rel >= abort_at)) begin
                in_valid = 1'b1; in_data = words[k]; in_last = (k == n_words - 1);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                k++;
                gap_rem = (k < n_words) ? gaps[k] : 0;
            end else if (in_ready && !in_valid && k < n_words && rel < len && gap_rem > 0) begin
                gap_rem--;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
        total += 2;
        if (stream_bad != 0) begin
            bad++; $display("FAIL %s det_stream: wrong_symbols=%0d want=0", name, stream_bad);
        end
        if (done_rel != len || done_cnt != 1) begin
            bad++; $display("FAIL %s frame_done: at=%0d pulses=%0d want_at=%0d pulses=1", name, done_rel, done_cnt, len);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        total += 5;
        if (in_ready !== 1'b1)      begin bad++; $display("FAIL reset in_ready: got=%b want=1", in_ready); end
        if (det_data !== 2'b00)     begin bad++; $display("FAIL reset det_data: got=%b want=00", det_data); end
        if (hit_count !== 8'd0)     begin bad++; $display("FAIL reset hit_count: got=%0d want=0", hit_count); end
        if (frame_done !== 1'b0)    begin bad++; $display("FAIL reset frame_done: got=%b want=0", frame_done); end
        if (frame_aborted !== 1'b0) begin bad++; $display("FAIL reset frame_aborted: got=%b want=0", frame_aborted); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        n_words = 1; words[0] = 8'hB2; abort_at = -1;
        run_frame("single_b2");
    endtask

    task automatic test_back_to_back();
        n_words = 2; words[0] = 8'h59; words[1] = 8'h00; gaps[1] = 0; abort_at = -1;
        run_frame("b2b_59_00");
    endtask

    task automatic test_zero_frame();
        n_words = 3; abort_at = -1;
        for (int i = 0; i < 3; i++) begin words[i] = 8'h00; gaps[i] = 0; end
        run_frame("zeros_x3");
    endtask

    task automatic test_saturate();
        n_words = 5; abort_at = -1;
        for (int i = 0; i < 5; i++) begin words[i] = 8'h59; gaps[i] = 0; end
        run_frame("sat_59_x5");
    endtask

    task automatic test_abort();
        n_words = 1; words[0] = 8'hB2; abort_at = 1;
        run_frame("abort_b2");
        abort_at = -1;
        run_frame("after_abort_b2");
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h59; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (det_data !== 2'b00)  begin bad++; $display("FAIL async_rst det_data: got=%b want=00", det_data); end
        if (in_ready !== 1'b1)   begin bad++; $display("FAIL async_rst in_ready: got=%b want=1", in_ready); end
        if (hit_count !== 8'd0)  begin bad++; $display("FAIL async_rst hit_count: got=%0d want=0", hit_count); end
        if (frame_aborted !== 1'b0) begin bad++; $display("FAIL async_rst frame_aborted: got=%b want=0", frame_aborted); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (frame_done !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL async_rst no_done: pulses=%0d want=0", seen); end
        n_words = 1; words[0] = 8'hB2; abort_at = -1;
        run_frame("post_reset_b2");
    endtask

    task automatic test_random();
        int full_len;
        for (int f = 0; f < 20; f++) begin
            n_words  = $urandom_range(1, 4);
            full_len = 0;
            for (int i = 0; i < n_words; i++) begin
                case ($urandom_range(0, 3))
                    0:       words[i] = 8'hB2;
                    1:       words[i] = 8'h59;
                    default: words[i] = 8'($urandom);
                endcase
                gaps[i]  = (i == 0) ? 0 : $urandom_range(0, 2);
                full_len += 4 + gaps[i];
            end
            abort_at = ($urandom_range(0, 9) < 3) ? $urandom_range(0, full_len + 1) : -1;
            run_frame($sformatf("rand%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_zero_frame();
        test_saturate();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
